// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM command-bus arbiter.
package sdram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } state_t;

   typedef enum logic {
      LAST_WR = 1'b0,
      LAST_RD = 1'b1
   } rw_t;

   localparam logic [1:0] SEL_INIT = 2'd0;
   localparam logic [1:0] SEL_AREF = 2'd1;
   localparam logic [1:0] SEL_WR   = 2'd2;
   localparam logic [1:0] SEL_RD   = 2'd3;

   localparam int REF_PERIOD_DEF = 780;
   localparam int TIMEOUT_DEF    = 1023;
   localparam int CNT_W_DEF      = 10;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh-interval timer: raises a sticky refresh request every REF_PERIOD
// cycles once initialisation is done; the refresh engine's end pulse clears it.
module sdram_ref_timer
   import sdram_pkg::*;
#(
   parameter int REF_PERIOD = REF_PERIOD_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic sclk,
   input  logic s_rst,
   input  logic init_done,
   input  logic aref_end,
   output logic aref_pend
);

   logic [CNT_W-1:0] ref_cnt;

   always_ff @(posedge sclk) begin
      if (s_rst || !init_done) begin
         ref_cnt   <= '0;
         aref_pend <= 1'b0;
      end else if (ref_cnt == CNT_W'(REF_PERIOD - 1)) begin
         // a new interval expiring outranks a coincident end pulse
         ref_cnt   <= '0;
         aref_pend <= 1'b1;
      end else begin
         ref_cnt <= ref_cnt + CNT_W'(1);
         if (aref_end)
            aref_pend <= 1'b0;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Command-bus arbiter: grants refresh, write-burst or read-burst engine one at
// a time after SDRAM init, with refresh priority, R/W alternation and a grant watchdog.
//
//   state | meaning
//   IDLE  | waiting for init_done, bus owned by init sequencer
//   ARBIT | one grant decision per cycle
//   AREF  | refresh engine owns the bus
//   WRITE | write-burst engine owns the bus
//   READ  | read-burst engine owns the bus
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int REF_PERIOD = REF_PERIOD_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic       sclk,
   input  logic       s_rst,
   input  logic       init_done,
   input  logic       aref_end,
   input  logic       wr_req,
   input  logic       wr_end,
   input  logic       rd_req,
   input  logic       rd_end,
   output logic       aref_en,
   output logic       wr_en,
   output logic       rd_en,
   output logic       wr_break,
   output logic       rd_break,
   output logic [1:0] bus_sel,
   output logic       timeout_err
);

   state_t           state;
   rw_t              last_rw;
   logic [CNT_W-1:0] to_cnt;
   logic             aref_pend;
   logic             grant_end;
   logic             to_hit;

   sdram_ref_timer #(
      .REF_PERIOD (REF_PERIOD),
      .CNT_W      (CNT_W)
   ) u_ref_timer (
      .sclk      (sclk),
      .s_rst     (s_rst),
      .init_done (init_done),
      .aref_end  (aref_end),
      .aref_pend (aref_pend)
   );

   always_comb begin
      grant_end = 1'b0;
      case (state)
         ST_AREF:  grant_end = aref_end;
         ST_WRITE: grant_end = wr_end;
         ST_READ:  grant_end = rd_end;
         default:  grant_end = 1'b0;
      endcase
   end

   assign to_hit = (to_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge sclk) begin
      if (s_rst) begin
         state       <= ST_IDLE;
         last_rw     <= LAST_RD;
         to_cnt      <= '0;
         aref_en     <= 1'b0;
         wr_en       <= 1'b0;
         rd_en       <= 1'b0;
         wr_break    <= 1'b0;
         rd_break    <= 1'b0;
         bus_sel     <= SEL_INIT;
         timeout_err <= 1'b0;
      end else if (!init_done) begin
         state    <= ST_IDLE;
         to_cnt   <= '0;
         aref_en  <= 1'b0;
         wr_en    <= 1'b0;
         rd_en    <= 1'b0;
         wr_break <= 1'b0;
         rd_break <= 1'b0;
         bus_sel  <= SEL_INIT;
      end else begin
         case (state)
            ST_IDLE: state <= ST_ARBIT;
            ST_ARBIT: begin
               to_cnt <= '0;
               if (aref_pend) begin
                  state   <= ST_AREF;
                  aref_en <= 1'b1;
                  bus_sel <= SEL_AREF;
               end else if (wr_req && (!rd_req || last_rw == LAST_RD)) begin
                  state   <= ST_WRITE;
                  wr_en   <= 1'b1;
                  bus_sel <= SEL_WR;
                  last_rw <= LAST_WR;
               end else if (rd_req) begin
                  state   <= ST_READ;
                  rd_en   <= 1'b1;
                  bus_sel <= SEL_RD;
                  last_rw <= LAST_RD;
               end
            end
            ST_AREF, ST_WRITE, ST_READ: begin
               if (grant_end || to_hit) begin
                  // an end pulse on the last allowed cycle still counts as clean
                  if (!grant_end)
                     timeout_err <= 1'b1;
                  state    <= ST_ARBIT;
                  aref_en  <= 1'b0;
                  wr_en    <= 1'b0;
                  rd_en    <= 1'b0;
                  wr_break <= 1'b0;
                  rd_break <= 1'b0;
                  bus_sel  <= SEL_INIT;
               end else begin
                  to_cnt   <= to_cnt + CNT_W'(1);
                  wr_break <= aref_pend && (state == ST_WRITE);
                  rd_break <= aref_pend && (state == ST_READ);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Sequences access to the shared SDRAM command/address bus once power-up initialisation completes.
- Arbitrates between three requesters inside the SDRAM top level:
  - the auto-refresh engine, which is fed by an internal refresh-interval timer,
  - the write-burst engine, which drains the UART write FIFO,
  - the read-burst engine, which fills the VGA read FIFO.
- Grants one engine at a time, tells the active burst engine to break early when a refresh falls due, and drives the command-mux select.

Parameters:
- REF_PERIOD, 780: sclk cycles between refresh requests (7.8 us at 100 MHz).
- TIMEOUT, 1023: maximum cycles a grant may stay open without an *_end pulse.
- CNT_W, 10: width of the refresh and timeout counters; must satisfy 2^CNT_W > max(REF_PERIOD, TIMEOUT).

Ports:
- sclk  in  1  system clock (100 MHz SDRAM domain)
- s_rst  in  1  synchronous, active-high reset
- init_done  in  1  SDRAM initialisation complete (level)
- aref_end  in  1  one-cycle pulse: refresh sequence finished
- wr_req  in  1  write engine has a burst pending (level)
- wr_end  in  1  one-cycle pulse: write burst finished
- rd_req  in  1  read engine has a burst pending (level)
- rd_end  in  1  one-cycle pulse: read burst finished
- aref_en  out  1  refresh grant
- wr_en  out  1  write grant
- rd_en  out  1  read grant
- wr_break  out  1  refresh pending; write engine ends its burst at the next legal point
- rd_break  out  1  refresh pending; read engine ends its burst at the next legal point
- bus_sel  out  2  command-mux owner: 0 init, 1 refresh, 2 write, 3 read
- timeout_err  out  1  sticky flag: a grant hit TIMEOUT

Behaviour:
- Reset values:
  - state = IDLE
  - all *_en, *_break and timeout_err = 0
  - bus_sel = 0
  - ref_cnt = 0, to_cnt = 0, aref_pend = 0, last_rw = read
- States: IDLE, ARBIT, AREF, WRITE, READ. All outputs are registered.
- IDLE: stays here while init_done = 0, with bus_sel = 0. Moves to ARBIT on the cycle after init_done is seen high.
- Refresh timer:
  - ref_cnt increments each cycle while init_done = 1 and wraps from REF_PERIOD-1 to 0.
  - At the wrap, aref_pend is set (sticky).
  - aref_end clears aref_pend. If the wrap and aref_end land on the same cycle, aref_pend stays 1.
  - When init_done = 0, ref_cnt is held at 0.
- ARBIT: one decision per cycle, and the grant is registered on the next edge.
  - Priority 1: aref_pend -> AREF.
  - Priority 2: wr_req and rd_req both high -> grant the opposite of last_rw (alternation).
  - Priority 3: only one of wr_req / rd_req high -> grant that one.
  - Nothing requesting -> stay in ARBIT.
  - last_rw is updated on every write or read grant.
- Grant states (AREF / WRITE / READ):
  - The matching *_en is high for the whole state.
  - bus_sel = 1 / 2 / 3 respectively.
  - On the matching *_end pulse, go back to ARBIT; *_en reads 0 from the next cycle.
  - *_end pulses for a non-granted engine are ignored.
  - Minimum grant length is 1 cycle; *_end in the first granted cycle is legal.
- Break signals:
  - wr_break = aref_pend while in WRITE.
  - rd_break = aref_pend while in READ.
  - Both are 0 in all other states.
- Timeout:
  - to_cnt resets to 0 on entry to any grant state and counts each cycle while in it.
  - If to_cnt reaches TIMEOUT without *_end: set timeout_err, drop the grant, return to ARBIT.
  - An aborted refresh leaves aref_pend set, so refresh is retried.
  - timeout_err clears only on s_rst.
- init_done falling in any state:
  - Next cycle: state = IDLE, all grants = 0, bus_sel = 0, aref_pend = 0.
- ARBIT never grants on the same cycle that a grant ends; there is always at least one ARBIT cycle between grants.
- s_rst mid-burst: every output returns to its reset value on the next edge.

Decomposition:
- Shared package sdram_pkg holds:
  - state encodings (IDLE/ARBIT/AREF/WRITE/READ),
  - bus_sel codes (SEL_INIT = 0, SEL_AREF = 1, SEL_WR = 2, SEL_RD = 3),
  - the default REF_PERIOD and TIMEOUT constants.
- One sub-module is natural: sdram_ref_timer. It contains ref_cnt and aref_pend, with inputs init_done and aref_end and output aref_pend.

Test Plan:
- Hold init_done = 0 for 200 cycles, then raise it -> bus_sel stays 0 and no grant during the hold. ARBIT is reached 1 cycle after the rise. First aref_en rises 780 +/- 2 cycles after the rise.
- wr_req = 1 alone, wr_end pulsed 40 cycles after wr_en -> wr_en high for exactly 40 cycles. bus_sel = 2 throughout, then returns to ARBIT.
- wr_req and rd_req both held high, each burst ending after 8 cycles -> grants alternate W, R, W, R with exactly one ARBIT cycle between them.
- Refresh falls due during a 100-cycle read -> rd_break rises the cycle after aref_pend sets. After rd_end, aref_en is granted ahead of a pending wr_req.
- Grant a write and never pulse wr_end -> wr_en drops after 1023 cycles and timeout_err = 1 (sticky). Next arbitration proceeds normally.
- init_done dropped mid-write, and separately s_rst mid-refresh -> next cycle all grants and breaks = 0, bus_sel = 0, state IDLE. After s_rst, timeout_err = 0.
